// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared state encoding, Gray symbol codes and 4-ASK level helper
package tx_sched_pkg;
    typedef enum logic [1:0] {IDLE, PRE, DATA, FLUSH} state_e;
    localparam logic [1:0] SYM_N3 = 2'b00;
    localparam logic [1:0] SYM_N1 = 2'b01;
    localparam logic [1:0] SYM_P1 = 2'b11;
    localparam logic [1:0] SYM_P3 = 2'b10;
    localparam logic [1:0] PRE_EVEN = SYM_P3;
    localparam logic [1:0] PRE_ODD = SYM_N3;
    localparam int OUTER_MULT = 3;
    function automatic int sym_level(input logic [1:0] s, input int a);
        return s == SYM_N3 ? -OUTER_MULT * a :
               s == SYM_N1 ? -a :
               s == SYM_P1 ? a : OUTER_MULT * a;
    endfunction
endpackage

// File: rtl/tx_sym_mapper.sv
// tx_sym_mapper: 2-bit Gray symbol to signed 4-ASK level
module tx_sym_mapper
    import tx_sched_pkg::*;
#(
    parameter int SAMP_W  = 18,
    parameter int LEVEL_A = 32768
) (
    input  logic [1:0]               sym_i,
    output logic signed [SAMP_W-1:0] lvl_o
);
    assign lvl_o = SAMP_W'(sym_level(sym_i, LEVEL_A));
endmodule

// File: rtl/tx_symbol_scheduler.sv
// tx_symbol_scheduler: preamble/payload/flush burst sequencer with 4-ASK mapping
// and x4 zero-stuffed sample output.
module tx_symbol_scheduler
    import tx_sched_pkg::*;
#(
    parameter int SAMP_W    = 18,
    parameter int LEVEL_A   = 32768,
    parameter int PRE_LEN   = 8,
    parameter int FLUSH_LEN = 16,
    parameter int LEN_W     = 16
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     sam_clk_ena,
    input  logic                     sym_clk_ena,
    input  logic                     start,
    input  logic [LEN_W-1:0]         burst_len,
    input  logic                     sym_valid,
    input  logic [1:0]               sym_i,
    input  logic [1:0]               sym_q,
    output logic                     sym_ready,
    output logic signed [SAMP_W-1:0] samp_i,
    output logic signed [SAMP_W-1:0] samp_q,
    output logic                     samp_valid,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               underflow_cnt
);
    localparam int PRE_W = $clog2(PRE_LEN) > 1 ? $clog2(PRE_LEN) : 1;
    localparam int FL_W = $clog2(FLUSH_LEN) > 1 ? $clog2(FLUSH_LEN) : 1;
    localparam int AUX_W = PRE_W > FL_W ? PRE_W : FL_W;
    localparam int CNT_W = LEN_W > AUX_W ? LEN_W : AUX_W;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [7:0]                 und_q, und_d;
    logic                       pend_q, pend_d;
    logic                       done_q, done_d;
    logic                       sv_q;
    logic signed [SAMP_W-1:0]   si_q, si_d, sq_q, sq_d, map_i, map_q;
    logic [1:0]                 code_i, code_q;
    logic                       accept, zero_sym;

    assign accept = start & (state_q == IDLE) & ~pend_q;
    assign zero_sym = ~((state_q == PRE) | ((state_q == DATA) & sym_valid));
    assign code_i = state_q == PRE ? (cnt_q[0] ? PRE_ODD : PRE_EVEN) : sym_i;
    assign code_q = state_q == PRE ? (cnt_q[0] ? PRE_ODD : PRE_EVEN) : sym_q;

    tx_sym_mapper #(.SAMP_W(SAMP_W), .LEVEL_A(LEVEL_A)) u_map_i (.sym_i(code_i), .lvl_o(map_i));
    tx_sym_mapper #(.SAMP_W(SAMP_W), .LEVEL_A(LEVEL_A)) u_map_q (.sym_i(code_q), .lvl_o(map_q));

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        pend_d = pend_q | accept;
        len_d = accept ? burst_len : len_q;
        und_d = accept ? 8'd0 : und_q;
        done_d = 1'b0;
        if (sym_clk_ena) begin
            cnt_d = cnt_q + CNT_W'(1);
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (pend_q) begin
                        pend_d = 1'b0;
                        state_d = PRE;
                    end
                end
                PRE: if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
                    state_d = len_q == '0 ? FLUSH : DATA;
                    cnt_d = '0;
                end
                DATA: begin
                    // an empty slot is still a payload slot, so it counts toward the length
                    if (!sym_valid && und_q != 8'hff) und_d = und_q + 8'd1;
                    if (cnt_q == CNT_W'(len_q) - CNT_W'(1)) begin
                        state_d = FLUSH;
                        cnt_d = '0;
                    end
                end
                FLUSH: if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
                    state_d = IDLE;
                    cnt_d = '0;
                    done_d = 1'b1;
                end
            endcase
        end
        si_d = sym_clk_ena ? (zero_sym ? '0 : map_i) : sam_clk_ena ? '0 : si_q;
        sq_d = sym_clk_ena ? (zero_sym ? '0 : map_q) : sam_clk_ena ? '0 : sq_q;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            len_q <= '0;
            und_q <= '0;
            pend_q <= 1'b0;
            done_q <= 1'b0;
            sv_q <= 1'b0;
            si_q <= '0;
            sq_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            und_q <= und_d;
            pend_q <= pend_d;
            done_q <= done_d;
            sv_q <= sam_clk_ena;
            si_q <= si_d;
            sq_q <= sq_d;
        end
    end

    assign sym_ready = (state_q == DATA) & sym_clk_ena;
    assign samp_i = si_q;
    assign samp_q = sq_q;
    assign samp_valid = sv_q;
    assign busy = (state_q != IDLE) | pend_q;
    assign done = done_q;
    assign underflow_cnt = und_q;
endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// tb_tx_symbol_scheduler: directed bursts with a boundary-sample scoreboard
module tb_tx_symbol_scheduler;
    localparam int SAMP_W = 18;
    localparam int PRE_LEN = 8;
    localparam int FLUSH_LEN = 16;
    localparam int LEN_W = 16;
    localparam int A3 = 98304;
    localparam int A1 = 32768;

    typedef struct {
        int i;
        int q;
    } smp_t;

    logic sys_clk = 0, reset = 1, sam_clk_ena = 0, sym_clk_ena = 0, start = 0;
    logic [LEN_W-1:0] burst_len = 0;
    logic sym_valid = 0;
    logic [1:0] sym_i = 2'b01, sym_q = 2'b11;
    logic sym_ready, samp_valid, busy, done;
    logic signed [SAMP_W-1:0] samp_i, samp_q;
    logic [7:0] underflow_cnt;

    smp_t exp_q[$];
    int n_cmp = 0, n_bad = 0, ph = 0, k = 0, base = 0, done_cnt = 0;
    bit vpat[0:511];
    logic exp_sv = 0, bnd_d = 0;

    tx_symbol_scheduler #(.SAMP_W(SAMP_W), .LEVEL_A(A1), .PRE_LEN(PRE_LEN),
        .FLUSH_LEN(FLUSH_LEN), .LEN_W(LEN_W)) dut (
        .sys_clk(sys_clk), .reset(reset), .sam_clk_ena(sam_clk_ena), .sym_clk_ena(sym_clk_ena),
        .start(start), .burst_len(burst_len), .sym_valid(sym_valid), .sym_i(sym_i), .sym_q(sym_q),
        .sym_ready(sym_ready), .samp_i(samp_i), .samp_q(samp_q), .samp_valid(samp_valid),
        .busy(busy), .done(done), .underflow_cnt(underflow_cnt));

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input int q);
        smp_t s;
        s.i = i;
        s.q = q;
        exp_q.push_back(s);
    endtask

    task automatic set_pat(input bit v);
        for (int j = 0; j < 512; j++) vpat[j] = v;
    endtask

    initial forever begin
        @(posedge sys_clk);
        #1;
        ph = (ph + 1) % 16;
        sam_clk_ena = (ph % 4) == 0;
        sym_clk_ena = ph == 0;
    end

    always @(posedge sys_clk or posedge reset)
        if (reset) begin
            exp_sv <= 1'b0;
            bnd_d <= 1'b0;
        end else begin
            exp_sv <= sam_clk_ena;
            bnd_d <= sym_clk_ena;
        end

    initial begin
        smp_t e;
        forever begin
            @(negedge sys_clk);
            if (done) done_cnt++;
            if (!reset) begin
                chk("samp_valid", samp_valid, exp_sv);
                if (samp_valid) begin
                    if (bnd_d && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("symbol_i", samp_i, e.i);
                        chk("symbol_q", samp_q, e.q);
                    end else begin
                        chk("zero_i", samp_i, 0);
                        chk("zero_q", samp_q, 0);
                    end
                end
            end
        end
    end

    initial begin
        bit r;
        forever begin
            @(negedge sys_clk);
            r = sym_ready;
            @(posedge sys_clk);
            #1;
            if (r) k++;
            sym_valid = (k - base) < 512 ? vpat[k - base] : 1'b0;
        end
    end

    task automatic launch(input int len, input bit coinc);
        if (coinc) begin
            do @(negedge sys_clk); while (ph != 15);
        end else begin
            do @(negedge sys_clk); while (!sym_clk_ena);
            @(negedge sys_clk);
        end
        @(posedge sys_clk);
        #1;
        start = 1;
        burst_len = LEN_W'(len);
        if (coinc) push(0, 0);
        push(0, 0);
        for (int p = 0; p < PRE_LEN; p++) push(p % 2 == 0 ? A3 : -A3, p % 2 == 0 ? A3 : -A3);
        for (int j = 0; j < len; j++) if (vpat[j]) push(-A1, A1); else push(0, 0);
        for (int f = 0; f < FLUSH_LEN; f++) push(0, 0);
        @(posedge sys_clk);
        #1;
        start = 0;
    endtask

    task automatic run_burst(input int len, input bit coinc, input bit busy_start);
        int d0, und, t;
        d0 = done_cnt;
        base = k;
        und = 0;
        for (int j = 0; j < len; j++) if (!vpat[j] && und < 255) und++;
        launch(len, coinc);
        if (busy_start) begin
            repeat (40) @(posedge sys_clk);
            #1;
            chk("busy_before_restart", busy, 1);
            start = 1;
            burst_len = 16'd7;
            @(posedge sys_clk);
            #1;
            start = 0;
        end
        t = 0;
        while (done_cnt == d0 && t < (len + 40) * 16) begin
            @(negedge sys_clk);
            t++;
        end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
        repeat (40) @(negedge sys_clk);
        chk("done_pulses", done_cnt - d0, 1);
        chk("ready_count", k - base, len);
        chk("underflow_cnt", underflow_cnt, und);
        chk("queue_drained", exp_q.size(), 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        int d0, nv;
        repeat (3) @(negedge sys_clk);
        chk("rst_samp_i", samp_i, 0);
        chk("rst_samp_q", samp_q, 0);
        chk("rst_samp_valid", samp_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sym_ready", sym_ready, 0);
        chk("rst_underflow", underflow_cnt, 0);
        @(posedge sys_clk);
        #1;
        reset = 0;
        repeat (20) @(posedge sys_clk);
        set_pat(1);
        run_burst(4, 0, 0);
        set_pat(1);
        vpat[1] = 0;
        run_burst(3, 0, 0);
        run_burst(0, 0, 0);
        set_pat(1);
        run_burst(2, 1, 1);
        set_pat(0);
        run_burst(300, 0, 0);
        set_pat(1);
        d0 = done_cnt;
        base = k;
        launch(4, 0);
        nv = 0;
        while (k - base < 2 && nv < 1000) begin
            @(negedge sys_clk);
            nv++;
        end
        chk("mid_data_reached", k - base, 2);
        repeat (3) @(posedge sys_clk);
        #1;
        reset = 1;
        exp_q.delete();
        @(negedge sys_clk);
        chk("mid_rst_samp_i", samp_i, 0);
        chk("mid_rst_samp_q", samp_q, 0);
        chk("mid_rst_samp_valid", samp_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sym_ready", sym_ready, 0);
        repeat (3) @(posedge sys_clk);
        #1;
        reset = 0;
        nv = 0;
        repeat (64) begin
            @(negedge sys_clk);
            if (samp_valid) nv++;
        end
        chk("post_rst_valid_count", nv, 16);
        chk("post_rst_no_done", done_cnt - d0, 0);
        chk("post_rst_busy", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
